// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer with a word-addressed 32-bit register file.
// Register 0 is a read-only ID and the others are R/W storage.
// Wait states are parameterised; illegal accesses are flagged on PSLVERR.
// Ports:
//   PCLK            bus clock, rising edge
//   PRESETn         asynchronous reset, active-high
//   PSEL/PENABLE    APB phase control from the master
//   PWRITE          1 = write, 0 = read
//   PADDR/PWDATA    byte address / write data
//   PRDATA          read data, qualified by PREADY
//   PREADY/PSLVERR  completion / error response (registered)
module apb_slave_regfile #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          NUM_REGS    = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int                   IW    = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] NREG = ADDR_WIDTH'(NUM_REGS);
    localparam logic [3:0]           WAITS = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] regs [1:NUM_REGS-1];

    // Transfer attributes captured in the setup phase
    logic [IW-1:0] l_idx;
    logic          l_write;
    logic [31:0]   l_wdata;
    logic          l_err;

    logic [ADDR_WIDTH-1:0] s_off;
    logic [ADDR_WIDTH-1:0] s_word;
    logic [IW-1:0]         s_idx;
    logic                  s_err;
    logic [31:0]           s_rdata;
    logic [31:0]           l_rdata;
    logic                  start;

    always_comb begin
        s_off  = PADDR - BASE;
        s_word = s_off >> 2;
        s_idx  = s_word[IW-1:0];
        s_err  = (PADDR[1:0] != 2'b00)
              || (PADDR < BASE)
              || (s_word >= NREG)
              || (PWRITE && (s_word == '0));
        s_rdata = '0;
        if (!s_err && !PWRITE)
            s_rdata = (s_idx == '0) ? ID_VALUE : regs[s_idx];
        l_rdata = '0;
        if (!l_err && !l_write)
            l_rdata = (l_idx == '0) ? ID_VALUE : regs[l_idx];
        // A setup is accepted when idle or on the cycle after DONE;
        // a setup seen while waiting is not a legal APB sequence.
        start = PSEL && !PENABLE && (state != WAIT);
    end

    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            state   <= IDLE;
            cnt     <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
            l_idx   <= '0;
            l_write <= 1'b0;
            l_wdata <= '0;
            l_err   <= 1'b0;
            for (int i = 1; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            unique case (state)
                IDLE: ;
                WAIT: begin
                    if (!PSEL) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (PENABLE) begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state   <= DONE;
                            PREADY  <= 1'b1;
                            PSLVERR <= l_err;
                            PRDATA  <= l_rdata;
                        end
                    end
                end
                DONE: begin
                    // Completion or abort both clear the response;
                    // only a real completion commits the write.
                    state   <= IDLE;
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= '0;
                    if (PSEL && PENABLE && l_write && !l_err)
                        regs[l_idx] <= l_wdata;
                end
                default: state <= IDLE;
            endcase

            // A new setup overrides the state/outputs chosen above
            if (start) begin
                l_idx   <= s_idx;
                l_write <= PWRITE;
                l_wdata <= PWDATA;
                l_err   <= s_err;
                cnt     <= WAITS;
                if (WAIT_CYCLES == 0) begin
                    state   <= DONE;
                    PREADY  <= 1'b1;
                    PSLVERR <= s_err;
                    PRDATA  <= s_rdata;
                end else begin
                    state <= WAIT;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: bench for apb_slave_regfile with 0, 3 and 2 wait states.
// Directed steps plus random transfers checked against a register-array model.
module tb_apb_slave_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata [3];
    logic [2:0]  pready;
    logic [2:0]  pslverr;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [3][16];

    localparam logic [31:0] ID = 32'hA5B0_0001;

    always #5 clk = ~clk;

    apb_slave_regfile #(.WAIT_CYCLES(0)) u_w0 (
        .PCLK(clk), .PRESETn(rst), .PSEL(psel[0]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );

    apb_slave_regfile #(.WAIT_CYCLES(3)) u_w3 (
        .PCLK(clk), .PRESETn(rst), .PSEL(psel[1]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
    );

    apb_slave_regfile #(.WAIT_CYCLES(2)) u_w2 (
        .PCLK(clk), .PRESETn(rst), .PSEL(psel[2]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2])
    );

    function automatic int waits(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 16; i++)
                mdl[d][i] = '0;
    endtask

    // Register file as seen from the bus: 16 words at byte 0
    task automatic model(input int d, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd,
                         output logic [31:0] rd, output bit err);
        int unsigned w;
        w   = a / 4;
        err = (a % 4 != 0) || (w >= 16) || (wr && w == 0);
        rd  = '0;
        if (!err && !wr)
            rd = (w == 0) ? ID : mdl[d][w];
        if (!err && wr)
            mdl[d][w] = wd;
    endtask

    // Entered and left at posedge+1; keep=1 leaves the bus for a
    // back-to-back setup with no idle cycle.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input bit keep,
                        input string tag);
        logic [31:0] er;
        bit          ee;
        int          n;
        bit          got;
        logic [31:0] rdv;
        logic        ev;
        model(d, wr, a, wd, er, ee);
        psel    = 3'b000;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = wd;
        @(posedge clk);
        #1;
        penable = 1'b1;
        paddr   = $urandom;
        pwdata  = $urandom;
        n   = 0;
        got = 1'b0;
        rdv = 'x;
        ev  = 1'bx;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (pready[d]) begin
                got = 1'b1;
                rdv = prdata[d];
                ev  = pslverr[d];
            end
        end
        chk({tag, " access-cycles"}, n, waits(d) + 1);
        chk({tag, " prdata"}, rdv, er);
        chk({tag, " pslverr"}, {31'b0, ev}, {31'b0, ee});
        @(posedge clk);
        #1;
        chk({tag, " pready-clear"}, {31'b0, pready[d]}, 32'd0);
        chk({tag, " prdata-clear"}, prdata[d], 32'd0);
        if (!keep) begin
            psel    = 3'b000;
            penable = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t0;
        rst     = 1'b1;
        psel    = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset pready", {31'b0, pready[d]}, 32'd0);
            chk("reset pslverr", {31'b0, pslverr[d]}, 32'd0);
            chk("reset prdata", prdata[d], 32'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Zero-wait write then read
        xfer(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 1'b0, "zw wr");
        xfer(0, 1'b0, 32'h8, 32'h0, 1'b0, "zw rd");

        // Three wait states reading the ID register
        xfer(1, 1'b0, 32'h0, 32'h0, 1'b0, "ws3 id");

        // Error responses
        xfer(0, 1'b1, 32'h0, 32'h1234, 1'b0, "err wr id");
        xfer(0, 1'b1, 32'h6, 32'h1, 1'b0, "err unaligned");
        xfer(0, 1'b0, 32'h40, 32'h0, 1'b0, "err range");
        xfer(0, 1'b0, 32'h0, 32'h0, 1'b0, "err id intact");

        // Back-to-back with no idle cycle between transfers
        t0 = $time;
        xfer(0, 1'b1, 32'h4, 32'h11, 1'b1, "b2b wr");
        xfer(0, 1'b0, 32'h4, 32'h0, 1'b1, "b2b rd");
        chk("b2b duration", 32'($time - t0), 32'd40);
        psel    = 3'b000;
        penable = 1'b0;
        @(posedge clk);
        #1;

        // Abort a 2-wait write after one access cycle
        psel    = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'hC;
        pwdata  = 32'h55;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(negedge clk);
        chk("abort wait pready", {31'b0, pready[2]}, 32'd0);
        @(posedge clk);
        #1;
        psel    = 3'b000;
        penable = 1'b0;
        @(posedge clk);
        #1;
        chk("abort idle pready", {31'b0, pready[2]}, 32'd0);
        xfer(2, 1'b0, 32'hC, 32'h0, 1'b0, "abort rd");

        // Random traffic across all three instances
        for (int k = 0; k < 60; k++) begin
            int          d;
            int          r;
            bit          wr;
            logic [31:0] a;
            d  = $urandom_range(0, 2);
            wr = 1'($urandom % 2);
            r  = $urandom_range(0, 9);
            if (r < 7)
                a = 32'($urandom_range(0, 15) * 4);
            else if (r == 7)
                a = 32'($urandom_range(0, 63));
            else
                a = 32'(64 + $urandom_range(0, 255) * 4);
            xfer(d, wr, a, $urandom, 1'($urandom % 2), "rand");
        end
        psel    = 3'b000;
        penable = 1'b0;
        @(posedge clk);
        #1;

        // Make register 1 non-zero, then reset in the middle of a read
        xfer(0, 1'b1, 32'h4, 32'h0000_0077, 1'b0, "pre-rst wr0");
        xfer(1, 1'b1, 32'h4, 32'h0000_0088, 1'b0, "pre-rst wr1");
        psel    = 3'b011;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(negedge clk);
        chk("mid pready w0", {31'b0, pready[0]}, 32'd1);
        chk("mid prdata w0", prdata[0], ID);
        chk("mid pready w3", {31'b0, pready[1]}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async pready", {31'b0, pready[0]}, 32'd0);
        chk("async prdata", prdata[0], 32'd0);
        chk("async pslverr", {31'b0, pslverr[0]}, 32'd0);
        psel    = 3'b000;
        penable = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++)
            xfer(d, 1'b0, 32'h4, 32'h0, 1'b0, "post-rst rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
